div_pipe_16bit: RTL and testbench
=================================

Name: div_pipe_16bit

Overview:
Fully pipelined unsigned integer divider. It is the inverse companion of the team's pipelined 8-bit multiplier and computes a 16-bit dividend divided by an 8-bit divisor, producing quotient and remainder. It accepts one operation per clock, uses a restoring algorithm with one quotient bit per stage, and carries a valid bit alongside the data. Output valid and result framing match the multiplier's en_in/en_out convention.

Parameters:
WIDTH_A, 16, dividend and quotient width
WIDTH_B, 8, divisor and remainder width; must satisfy 1 <= WIDTH_B <= WIDTH_A

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
div_en_in  input  1  operand valid; operands sampled when high
div_a  input  WIDTH_A  dividend, unsigned
div_b  input  WIDTH_B  divisor, unsigned
div_en_out  output  1  result valid
div_q  output  WIDTH_A  quotient
div_r  output  WIDTH_B  remainder
div_zero  output  1  divide-by-zero flag, qualified by div_en_out

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is synchronous and active-low. It is sampled only on the rising edge of clk.
- Reset values:
  - div_en_out = 0, div_q = 0, div_r = 0, div_zero = 0.
  - All internal valid bits and data registers = 0.
- Stage 0, input register:
  - Captures div_a and div_b when div_en_in = 1.
  - Otherwise loads zeros, which gates stale operands.
  - Captures the valid bit div_en_in.
  - Captures a zero flag equal to (div_b == 0).
- Stages 1..WIDTH_A, iteration stages. Stage k handles dividend bit WIDTH_A-k.
  - Partial remainder is WIDTH_B+1 bits wide. Shifted = {rem, dividend bit}.
  - If shifted >= divisor: rem = shifted - divisor and the quotient bit = 1.
  - Otherwise: rem = shifted and the quotient bit = 0.
  - The divisor, partial quotient, valid bit and zero flag pipeline with the data.
- Output stage:
  - When the final-stage valid bit is 1, register div_en_out = 1 and div_q/div_r from the final stage.
  - div_zero follows the zero flag.
  - Otherwise div_en_out = 0 and div_q, div_r, div_zero are all driven to 0.
- Latency:
  - Operands sampled at rising edge N produce the result at edge N + WIDTH_A + 2 (18 with defaults).
  - div_en_out is high for exactly one cycle per accepted operation.
- Throughput: one operation per cycle. Back-to-back inputs produce back-to-back outputs in order, with no stalls.
- Bubbles: a cycle with div_en_in = 0 produces exactly one output cycle with div_en_out = 0 and all result outputs 0, at the same latency.
- Divide by zero (div_b = 0):
  - div_q = all ones, div_r = 0, div_zero = 1.
  - Latency is unchanged and the pipeline is not disturbed.
- Arithmetic:
  - Result satisfies div_a = div_q*div_b + div_r, with div_r < div_b.
  - Dividend smaller than divisor gives q = 0, r = dividend.
  - No overflow is possible: the quotient fits in WIDTH_A.
- Reset mid-operation:
  - All in-flight operations are discarded.
  - div_en_out stays 0 until an operation accepted after reset release completes, at full latency.
  - No partial or corrupted result is ever flagged valid.
- No backpressure; the downstream must accept every div_en_out cycle.

Test Plan:
- Basic divide: sample 1000 / 7 at edge N -> at edge N+18, div_en_out = 1, div_q = 142, div_r = 6, div_zero = 0. div_en_out is 0 in the cycles before and after.
- Back-to-back: feed 65535/255, 65535/1, 12345/100, 5/200 on four consecutive cycles -> four consecutive valid outputs:
  - q = 257, r = 0
  - q = 65535, r = 0
  - q = 123, r = 45
  - q = 0, r = 5
- Divide by zero: feed 500/0 -> after 18 cycles, div_en_out = 1, div_q = 16'hFFFF, div_r = 0, div_zero = 1. A following 9/3 on the next cycle gives q = 3, r = 0, div_zero = 0.
- Bubble gating: div_en_in pattern 1,0,1 with operands 100/9, 77/7 (garbage operands during the 0 cycle) -> outputs in order:
  - valid q = 11, r = 1
  - an invalid cycle with q = r = 0
  - valid q = 11, r = 0
- Reset mid-stream:
  - Issue 6 operations, then pull rst_n low for 1 cycle at edge N+5.
  - Required: div_en_out never asserts for those 6 operations, and all outputs read 0 after reset.
  - Then 200/13 issued after release yields q = 15, r = 5 at full 18-cycle latency.
- Randomized sweep: 10,000 random valid/bubble operands including divisor 0 and 1 -> every output matches the reference model and the latency checker.

Source files
------------

// File: rtl/div_pipe_16bit.sv
// div_pipe_16bit: fully pipelined restoring divider, one quotient bit per stage.
// Stage 0 registers operands, stages 1..WIDTH_A iterate, then a result stage and the output register.
module div_pipe_16bit #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               div_en_in,
  input  logic [WIDTH_A-1:0] div_a,
  input  logic [WIDTH_B-1:0] div_b,
  output logic               div_en_out,
  output logic [WIDTH_A-1:0] div_q,
  output logic [WIDTH_B-1:0] div_r,
  output logic               div_zero
);
  // a_q holds the unconsumed dividend bits at the top, quotient bits shift in at the bottom
  logic [WIDTH_A:0][WIDTH_A-1:0]   a_q, a_d;
  logic [WIDTH_A:0][WIDTH_B-1:0]   rem_q, rem_d;
  logic [WIDTH_A-1:0][WIDTH_B-1:0] b_q, b_d;
  logic [WIDTH_A:0]                v_q, v_d, z_q, z_d;
  logic                            fv_q, fv_d, fz_q, fz_d;
  logic [WIDTH_A-1:0]              fq_q, fq_d;
  logic [WIDTH_B-1:0]              fr_q, fr_d;
  logic                            en_out_q, en_out_d, zero_q, zero_d;
  logic [WIDTH_A-1:0]              q_q, q_d;
  logic [WIDTH_B-1:0]              r_q, r_d;
  logic [WIDTH_B:0]                sh;
  logic                            ge;
  always_comb begin
    a_d = '0;
    rem_d = '0;
    b_d = '0;
    v_d = '0;
    z_d = '0;
    sh = '0;
    ge = 1'b0;
    v_d[0] = div_en_in;
    a_d[0] = div_en_in ? div_a : '0;
    b_d[0] = div_en_in ? div_b : '0;
    z_d[0] = (b_d[0] == '0);
    for (int k = 1; k <= WIDTH_A; k++) begin
      sh = {rem_q[k-1], a_q[k-1][WIDTH_A-1]};
      ge = sh >= {1'b0, b_q[k-1]};
      rem_d[k] = WIDTH_B'(ge ? sh - {1'b0, b_q[k-1]} : sh);
      a_d[k] = (a_q[k-1] << 1) | WIDTH_A'(ge);
      v_d[k] = v_q[k-1];
      z_d[k] = z_q[k-1];
    end
    for (int k = 1; k < WIDTH_A; k++) b_d[k] = b_q[k-1];
    // bubbles carry zeroed operands that look like a divide by zero, so gate on valid here
    fv_d = v_q[WIDTH_A];
    fz_d = v_q[WIDTH_A] & z_q[WIDTH_A];
    fq_d = !v_q[WIDTH_A] ? '0 : z_q[WIDTH_A] ? '1 : a_q[WIDTH_A];
    fr_d = (v_q[WIDTH_A] && !z_q[WIDTH_A]) ? rem_q[WIDTH_A] : '0;
    en_out_d = fv_q;
    q_d = fv_q ? fq_q : '0;
    r_d = fv_q ? fr_q : '0;
    zero_d = fv_q & fz_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      rem_q <= '0;
      b_q <= '0;
      v_q <= '0;
      z_q <= '0;
      fv_q <= 1'b0;
      fz_q <= 1'b0;
      fq_q <= '0;
      fr_q <= '0;
      en_out_q <= 1'b0;
      zero_q <= 1'b0;
      q_q <= '0;
      r_q <= '0;
    end else begin
      a_q <= a_d;
      rem_q <= rem_d;
      b_q <= b_d;
      v_q <= v_d;
      z_q <= z_d;
      fv_q <= fv_d;
      fz_q <= fz_d;
      fq_q <= fq_d;
      fr_q <= fr_d;
      en_out_q <= en_out_d;
      zero_q <= zero_d;
      q_q <= q_d;
      r_q <= r_d;
    end
  end
  assign div_en_out = en_out_q;
  assign div_q = q_q;
  assign div_r = r_q;
  assign div_zero = zero_q;
endmodule

// File: tb/tb_div_pipe_16bit.sv
// tb_div_pipe_16bit: directed and random checks of the pipelined divider.
module tb_div_pipe_16bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_en_in = 1'b0;
  logic [15:0] div_a = '0;
  logic [7:0]  div_b = '0;
  logic        div_en_out;
  logic [15:0] div_q;
  logic [7:0]  div_r;
  logic        div_zero;
  logic [25:0] obs;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  div_pipe_16bit dut (
    .clk(clk), .rst_n(rst_n), .div_en_in(div_en_in), .div_a(div_a), .div_b(div_b),
    .div_en_out(div_en_out), .div_q(div_q), .div_r(div_r), .div_zero(div_zero)
  );
  // {en_out, q, r, zero}
  assign obs = {div_en_out, div_q, div_r, div_zero};
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    div_en_in = 1'b0;
    div_a = '0;
    div_b = '0;
  endtask
  function automatic logic [25:0] ref_out(input logic en, input logic [15:0] a, input logic [7:0] b);
    logic [15:0] bb;
    bb = {8'h00, b};
    if (!en) return '0;
    if (b == 8'd0) return {1'b1, 16'hFFFF, 8'h00, 1'b1};
    return {1'b1, a / bb, 8'(a % bb), 1'b0};
  endfunction
  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      div_en_in = 1'b1;
      div_a = 16'(1000 + i);
      div_b = 8'd3;
      step;
      total++;
      if (obs !== 26'h0) $display("FAIL reset_hold: got %h expected %h", obs, 26'h0);
      else passed++;
    end
    idle;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step;
      total++;
      if (obs !== 26'h0) $display("FAIL reset_release cyc %0d: got %h expected %h", i, obs, 26'h0);
      else passed++;
    end
  endtask
  task automatic test_basic;
    logic [25:0] e;
    e = {1'b1, 16'd142, 8'd6, 1'b0};
    div_en_in = 1'b1;
    div_a = 16'd1000;
    div_b = 8'd7;
    step;
    idle;
    repeat (17) step;
    total++;
    if (div_en_out !== 1'b0) $display("FAIL basic_before: en_out %b expected 0", div_en_out);
    else passed++;
    step;
    total++;
    if (obs !== e) $display("FAIL basic: got %h expected %h", obs, e);
    else passed++;
    step;
    total++;
    if (div_en_out !== 1'b0) $display("FAIL basic_after: en_out %b expected 0", div_en_out);
    else passed++;
  endtask
  task automatic test_back_to_back;
    logic [15:0] av [4];
    logic [7:0]  bv [4];
    logic [25:0] ev [4];
    av = '{16'd65535, 16'd65535, 16'd12345, 16'd5};
    bv = '{8'd255, 8'd1, 8'd100, 8'd200};
    ev = '{{1'b1, 16'd257, 8'd0, 1'b0}, {1'b1, 16'd65535, 8'd0, 1'b0},
           {1'b1, 16'd123, 8'd45, 1'b0}, {1'b1, 16'd0, 8'd5, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      div_en_in = 1'b1;
      div_a = av[i];
      div_b = bv[i];
      step;
    end
    idle;
    repeat (15) step;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== ev[i]) $display("FAIL b2b[%0d]: got %h expected %h", i, obs, ev[i]);
      else passed++;
      step;
    end
    total++;
    if (div_en_out !== 1'b0) $display("FAIL b2b_after: en_out %b expected 0", div_en_out);
    else passed++;
  endtask
  task automatic test_div_zero;
    logic [25:0] e0, e1;
    e0 = {1'b1, 16'hFFFF, 8'd0, 1'b1};
    e1 = {1'b1, 16'd3, 8'd0, 1'b0};
    div_en_in = 1'b1;
    div_a = 16'd500;
    div_b = 8'd0;
    step;
    div_a = 16'd9;
    div_b = 8'd3;
    step;
    idle;
    repeat (17) step;
    total++;
    if (obs !== e0) $display("FAIL div_zero: got %h expected %h", obs, e0);
    else passed++;
    step;
    total++;
    if (obs !== e1) $display("FAIL div_zero_next: got %h expected %h", obs, e1);
    else passed++;
  endtask
  task automatic test_bubble;
    logic [25:0] ev [3];
    ev = '{{1'b1, 16'd11, 8'd1, 1'b0}, 26'h0, {1'b1, 16'd11, 8'd0, 1'b0}};
    div_en_in = 1'b1;
    div_a = 16'd100;
    div_b = 8'd9;
    step;
    div_en_in = 1'b0;
    div_a = 16'd1234;
    div_b = 8'd0;
    step;
    div_en_in = 1'b1;
    div_a = 16'd77;
    div_b = 8'd7;
    step;
    idle;
    repeat (16) step;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== ev[i]) $display("FAIL bubble[%0d]: got %h expected %h", i, obs, ev[i]);
      else passed++;
      step;
    end
  endtask
  task automatic test_reset_mid;
    logic [25:0] e;
    e = {1'b1, 16'd15, 8'd5, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (i == 5) rst_n = 1'b0;
      div_en_in = 1'b1;
      div_a = 16'(4000 + 37 * i);
      div_b = 8'(3 + i);
      step;
    end
    rst_n = 1'b1;
    idle;
    total++;
    if (obs !== 26'h0) $display("FAIL reset_mid_edge: got %h expected %h", obs, 26'h0);
    else passed++;
    for (int i = 0; i < 22; i++) begin
      step;
      total++;
      if (obs !== 26'h0) $display("FAIL reset_mid cyc %0d: got %h expected %h", i, obs, 26'h0);
      else passed++;
    end
    div_en_in = 1'b1;
    div_a = 16'd200;
    div_b = 8'd13;
    step;
    idle;
    repeat (17) step;
    total++;
    if (div_en_out !== 1'b0) $display("FAIL reset_mid_early: en_out %b expected 0", div_en_out);
    else passed++;
    step;
    total++;
    if (obs !== e) $display("FAIL reset_mid_after: got %h expected %h", obs, e);
    else passed++;
  endtask
  task automatic test_sweep;
    logic [25:0] sb [$];
    logic [25:0] e;
    logic        en;
    logic [15:0] a;
    logic [7:0]  b;
    int          sel;
    for (int i = 0; i < 10000 + 18; i++) begin
      if (i < 10000) begin
        en = ($urandom_range(0, 3) != 0);
        sel = int'($urandom_range(0, 7));
        a = (sel == 2) ? 16'hFFFF : 16'($urandom);
        b = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : 8'($urandom);
      end else begin
        en = 1'b0;
        a = '0;
        b = '0;
      end
      div_en_in = en;
      div_a = a;
      div_b = b;
      sb.push_back(ref_out(en, a, b));
      step;
      if (i >= 18) begin
        e = sb.pop_front();
        total++;
        if (obs !== e) $display("FAIL sweep op %0d: got %h expected %h", i - 18, obs, e);
        else passed++;
      end
    end
    idle;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_div_zero;
    test_bubble;
    test_reset_mid;
    test_sweep;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
